// File: rtl/clk_div_ramp_ctrl_pkg.sv
// Shared constants and the controller state encoding for the divider ramp controller.
package clk_div_pkg;

    localparam int DIV_W       = 8;
    localparam int DIV_RST_VAL = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/clk_div_ramp_ctrl_if.sv
// Host request handshake and divider load bus for the ramp controller.
// The host drives the request side and watches progress; the controller drives the rest.
interface clk_div_ramp_ctrl_if #(
    parameter int DW = clk_div_pkg::DIV_W
);

    logic [DW-1:0] req_div_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          abort_i;
    logic [DW-1:0] div_data_o;
    logic          div_en_o;
    logic [DW-1:0] cur_div_o;
    logic          busy_o;
    logic          done_o;
    logic          clamp_o;

    modport master (
        output req_div_i, req_valid_i, abort_i,
        input  req_ready_o, div_data_o, div_en_o, cur_div_o, busy_o, done_o, clamp_o
    );

    modport slave (
        input  req_div_i, req_valid_i, abort_i,
        output req_ready_o, div_data_o, div_en_o, cur_div_o, busy_o, done_o, clamp_o
    );

endinterface

// File: rtl/clk_div_step_tmr.sv
// Pacing timer: counts STEP_WAIT enabled cycles and emits a one-cycle tick on the last one.
// Clearing reloads the full period so the next tick lands STEP_WAIT enabled cycles later.
module clk_div_step_tmr #(
    parameter int STEP_WAIT = 16
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW     = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(STEP_WAIT - 1);

    logic [CW-1:0] cnt_q;

    // Down-counter that wraps back to the full period after each tick.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else if (clr_i) begin
            cnt_q <= RELOAD;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= RELOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/clk_div_ramp_ctrl.sv
// Divider ramp controller: accepts a target ratio, clamps it, and steps the divider
// towards it with paced one-cycle load strobes so the output clock never jumps abruptly.
module clk_div_ramp_ctrl
    import clk_div_pkg::*;
#(
    parameter int DW        = DIV_W,
    parameter int DIV_MIN   = 1,
    parameter int DIV_MAX   = 255,
    parameter int STEP      = 1,
    parameter int STEP_WAIT = 16,
    parameter int RAMP_EN   = 1
) (
    input logic                  clk_i,
    input logic                  rst_n,
    clk_div_ramp_ctrl_if.slave   bus
);

    localparam int            STEP_SAT = (DW < 31 && STEP > (2**DW) - 1) ? (2**DW) - 1 : STEP;
    localparam logic [DW-1:0] MIN_V    = DW'(DIV_MIN);
    localparam logic [DW-1:0] MAX_V    = DW'(DIV_MAX);
    localparam logic [DW-1:0] STEP_V   = DW'(STEP_SAT);
    localparam logic [DW-1:0] RST_V    = DW'(DIV_RST_VAL);

    ctrl_state_e   state_q, state_d;
    logic [DW-1:0] target_q;
    logic [DW-1:0] cur_q;
    logic [DW-1:0] data_q;
    logic          en_q;
    logic          done_q;
    logic          clamp_q;
    logic          busy_q;

    logic          accept;
    logic [DW-1:0] req_clamped;
    logic [DW-1:0] step_tgt;
    logic [DW-1:0] next_div;
    logic          load;
    logic          done_d;
    logic          tick;

    assign accept   = bus.req_valid_i && (state_q == IDLE);
    // While idle the first step is taken straight from the incoming request.
    assign step_tgt = (state_q == IDLE) ? req_clamped : target_q;

    // Clamp the request into the legal ratio range before any arithmetic uses it.
    always_comb begin
        req_clamped = bus.req_div_i;
        if (bus.req_div_i < MIN_V) begin
            req_clamped = MIN_V;
        end else if (bus.req_div_i > MAX_V) begin
            req_clamped = MAX_V;
        end
    end

    // Next ratio: move by at most STEP toward the target, landing exactly on it when close.
    always_comb begin
        next_div = step_tgt;
        if (RAMP_EN != 0) begin
            if (step_tgt > cur_q) begin
                if ((step_tgt - cur_q) > STEP_V) begin
                    next_div = cur_q + STEP_V;
                end
            end else if ((cur_q - step_tgt) > STEP_V) begin
                next_div = cur_q - STEP_V;
            end
        end
    end

    // Next-state logic; a target reached is confirmed one cycle after its load strobe.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_clamped == cur_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RAMP;
                        load    = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (cur_q == target_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, ratio tracking and registered status/strobe outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= RST_V;
            cur_q    <= RST_V;
            data_q   <= RST_V;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            clamp_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= load;
            done_q  <= done_d;
            clamp_q <= accept && (req_clamped != bus.req_div_i);
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                target_q <= req_clamped;
            end
            if (load) begin
                data_q <= next_div;
                cur_q  <= next_div;
            end
        end
    end

    clk_div_step_tmr #(
        .STEP_WAIT (STEP_WAIT)
    ) u_step_tmr (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .en_i   (state_q == RAMP),
        .tick_o (tick)
    );

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.div_data_o  = data_q;
    assign bus.div_en_o    = en_q;
    assign bus.cur_div_o   = cur_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.clamp_o     = clamp_q;

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Directed bench for the divider ramp controller: a per-cycle vector table for the
// basic ramps plus hand sequences for clamp, abort, reset and direct-load corners.
module tb_clk_div_ramp_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    clk_div_ramp_ctrl_if #(.DW(8)) busA ();
    clk_div_ramp_ctrl_if #(.DW(8)) busB ();

    clk_div_ramp_ctrl #(
        .DW(8), .DIV_MIN(1), .DIV_MAX(255), .STEP(1), .STEP_WAIT(4), .RAMP_EN(1)
    ) dutA (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    clk_div_ramp_ctrl #(
        .DW(8), .DIV_MIN(1), .DIV_MAX(200), .STEP(1), .STEP_WAIT(4), .RAMP_EN(0)
    ) dutB (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    typedef struct {
        logic       valid;
        logic [7:0] req;
        logic       abort;
        logic       en;
        logic [7:0] data;
        logic [7:0] cur;
        logic       rdy;
        logic       busy;
        logic       done;
        logic       clamp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vec [NVEC];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [7:0] r, input logic ab,
                                input logic en, input logic [7:0] d, input logic [7:0] c,
                                input logic rdy, input logic busy, input logic done,
                                input logic clamp);
        vec_t t;
        t.valid = v;  t.req  = r;  t.abort = ab;
        t.en    = en; t.data = d;  t.cur   = c;
        t.rdy   = rdy; t.busy = busy; t.done = done; t.clamp = clamp;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic en, input logic [7:0] d,
                            input logic [7:0] c, input logic rdy, input logic busy,
                            input logic done, input logic clamp);
        checkOutput({tag, " div_en"},   busA.div_en_o,   en);
        checkOutput({tag, " div_data"}, busA.div_data_o, d);
        checkOutput({tag, " cur_div"},  busA.cur_div_o,  c);
        checkOutput({tag, " ready"},    busA.req_ready_o, rdy);
        checkOutput({tag, " busy"},     busA.busy_o,     busy);
        checkOutput({tag, " done"},     busA.done_o,     done);
        checkOutput({tag, " clamp"},    busA.clamp_o,    clamp);
    endtask

    // Drive host inputs of the stepped instance just after the active edge.
    task automatic applyStimulus(input logic v, input logic [7:0] r, input logic ab);
        @(posedge clk);
        #1;
        busA.req_valid_i = v;
        busA.req_div_i   = r;
        busA.abort_i     = ab;
    endtask

    // Drive host inputs of the direct-load instance just after the active edge.
    task automatic applyStimulusB(input logic v, input logic [7:0] r);
        @(posedge clk);
        #1;
        busB.req_valid_i = v;
        busB.req_div_i   = r;
    endtask

    initial begin
        int enCount;
        int doneCount;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        busA.req_valid_i = 1'b0; busA.req_div_i = 8'd0; busA.abort_i = 1'b0;
        busB.req_valid_i = 1'b0; busB.req_div_i = 8'd0; busB.abort_i = 1'b0;

        // Idle, then ramp 1->4 (accept at c0), then back 4->2 accepted on the ready cycle.
        vec[0]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        vec[1]  = mk(0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        vec[2]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        vec[3]  = mk(1, 4, 0, 0, 1, 1, 1, 0, 0, 0);
        vec[4]  = mk(0, 0, 0, 1, 2, 2, 0, 1, 0, 0);
        vec[5]  = mk(0, 0, 0, 0, 2, 2, 0, 1, 0, 0);
        vec[6]  = mk(0, 0, 0, 0, 2, 2, 0, 1, 0, 0);
        vec[7]  = mk(0, 0, 0, 0, 2, 2, 0, 1, 0, 0);
        vec[8]  = mk(0, 0, 0, 1, 3, 3, 0, 1, 0, 0);
        vec[9]  = mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0);
        vec[10] = mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0);
        vec[11] = mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0);
        vec[12] = mk(0, 0, 0, 1, 4, 4, 0, 1, 0, 0);
        vec[13] = mk(0, 0, 1, 0, 4, 4, 0, 1, 1, 0);
        vec[14] = mk(1, 2, 0, 0, 4, 4, 1, 0, 0, 0);
        vec[15] = mk(0, 0, 0, 1, 3, 3, 0, 1, 0, 0);
        vec[16] = mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0);
        vec[17] = mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0);
        vec[18] = mk(0, 0, 0, 0, 3, 3, 0, 1, 0, 0);
        vec[19] = mk(0, 0, 0, 1, 2, 2, 0, 1, 0, 0);
        vec[20] = mk(0, 0, 0, 0, 2, 2, 0, 1, 1, 0);
        vec[21] = mk(0, 0, 0, 0, 2, 2, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 1, 1, 1, 0, 0, 0);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vec[i].valid, vec[i].req, vec[i].abort);
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vec[i].en, vec[i].data, vec[i].cur,
                     vec[i].rdy, vec[i].busy, vec[i].done, vec[i].clamp);
        end

        $display("[TB] reset back to ratio 1");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkAll("rst_from2", 0, 1, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] request below minimum");
        applyStimulus(1, 0, 0);
        enCount = 0;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 0, 0);
            @(negedge clk);
            if (busA.div_en_o === 1'b1) enCount++;
            if (c == 1) checkAll("clampLo c1", 0, 1, 1, 0, 1, 1, 1);
            if (c == 2) checkAll("clampLo c2", 0, 1, 1, 1, 0, 0, 0);
        end
        checkOutput("clampLo pulses", enCount, 0);

        $display("[TB] abort on third step");
        applyStimulus(1, 10, 0);
        enCount = 0;
        doneCount = 0;
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(0, 0, (c == 8));
            @(negedge clk);
            if (busA.div_en_o === 1'b1) enCount++;
            if (busA.done_o === 1'b1) doneCount++;
            if (c == 1) checkAll("abort c1", 1, 2, 2, 0, 1, 0, 0);
            if (c == 5) checkAll("abort c5", 1, 3, 3, 0, 1, 0, 0);
            if (c == 9) checkAll("abort c9", 0, 3, 3, 1, 0, 0, 0);
        end
        checkOutput("abort pulses", enCount, 2);
        checkOutput("abort dones", doneCount, 0);

        $display("[TB] reset mid-ramp");
        applyStimulus(1, 10, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkAll("midRamp c1", 1, 4, 4, 0, 1, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkAll("midRamp rst", 0, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        checkAll("midRamp hold", 0, 1, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] abort ignored while idle");
        applyStimulus(1, 2, 1);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkAll("idleAbort c1", 1, 2, 2, 0, 1, 0, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkAll("idleAbort c2", 0, 2, 2, 0, 1, 1, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkAll("idleAbort c3", 0, 2, 2, 1, 0, 0, 0);

        $display("[TB] direct load instance");
        applyStimulusB(1, 200);
        @(negedge clk);
        checkOutput("B c0 ready", busB.req_ready_o, 1);
        checkOutput("B c0 cur",   busB.cur_div_o, 1);
        applyStimulusB(0, 0);
        @(negedge clk);
        checkOutput("B c1 en",    busB.div_en_o, 1);
        checkOutput("B c1 data",  busB.div_data_o, 200);
        checkOutput("B c1 cur",   busB.cur_div_o, 200);
        checkOutput("B c1 done",  busB.done_o, 0);
        applyStimulusB(0, 0);
        @(negedge clk);
        checkOutput("B c2 en",    busB.div_en_o, 0);
        checkOutput("B c2 done",  busB.done_o, 1);
        checkOutput("B c2 ready", busB.req_ready_o, 0);
        applyStimulusB(0, 0);
        @(negedge clk);
        checkOutput("B c3 ready", busB.req_ready_o, 1);
        checkOutput("B c3 done",  busB.done_o, 0);

        applyStimulusB(1, 250);
        applyStimulusB(0, 0);
        @(negedge clk);
        checkOutput("B hi clamp", busB.clamp_o, 1);
        checkOutput("B hi done",  busB.done_o, 1);
        checkOutput("B hi en",    busB.div_en_o, 0);
        checkOutput("B hi cur",   busB.cur_div_o, 200);
        applyStimulusB(0, 0);
        @(negedge clk);
        checkOutput("B hi c2 clamp", busB.clamp_o, 0);
        checkOutput("B hi c2 ready", busB.req_ready_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
